change_dispenser: RTL and testbench

//  Payout end of the refund path. Accepts a refund amount from the vending FSM and pays it out one coin at a time.

---
 rtl/change_dispenser_if.sv | 39 +++
 rtl/change_dispenser.sv | 211 +++++++++++++++++++++
 tb/tb_change_dispenser.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - refund, hopper, refill and status signals of the change dispenser
interface change_dispenser_if #(
    parameter int AMT_W = 7,
    parameter int CNT_W = 4
);
    // refund request from the vending FSM
    logic             refund_valid;
    logic [AMT_W-1:0] refund_amt;
    logic             refund_ready;

    // coin hopper, 4-phase req/ack
    logic             coin_req;
    logic [1:0]       coin_out;
    logic             coin_ack;

    // inventory refill
    logic             load;
    logic [1:0]       load_coin;
    logic [CNT_W-1:0] load_qty;

    // status
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic             fault;
    logic [2:0]       coin_empty;

    // requester / hopper / refill side
    modport master (
        output refund_valid, refund_amt, coin_ack, load, load_coin, load_qty,
        input  refund_ready, coin_req, coin_out, busy, done, shortfall, fault, coin_empty
    );

    // dispenser side
    modport slave (
        input  refund_valid, refund_amt, coin_ack, load, load_coin, load_qty,
        output refund_ready, coin_req, coin_out, busy, done, shortfall, fault, coin_empty
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout with hopper handshake, inventory and shortfall reporting
module change_dispenser #(
    parameter int AMT_W       = 7,
    parameter int CNT_W       = 4,
    parameter int INIT_CNT5   = 10,
    parameter int INIT_CNT2   = 10,
    parameter int INIT_CNT1   = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    change_dispenser_if.slave  bus
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] COIN_1    = 2'b00;
    localparam logic [1:0] COIN_2    = 2'b01;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PAY,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] shortfall_q, shortfall_d;
    logic [CNT_W-1:0] cnt5_q, cnt5_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             coin_req_q, coin_req_d;
    logic [1:0]       coin_out_q, coin_out_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [2:0]       empty_q, empty_d;

    // Refill add that clamps at the counter maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] qty);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, qty};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Rupee value of a hopper coin code.
    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return AMT_W'(1);
            COIN_2:  return AMT_W'(2);
            COIN_5:  return AMT_W'(5);
            default: return '0;
        endcase
    endfunction

    // Next-state and registered-output logic for the payout FSM.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        shortfall_d = shortfall_q;
        cnt5_d      = cnt5_q;
        cnt2_d      = cnt2_q;
        cnt1_d      = cnt1_q;
        tmo_d       = tmo_q;
        coin_req_d  = coin_req_q;
        coin_out_d  = coin_out_q;
        done_d      = 1'b0;
        fault_d     = fault_q;

        case (state_q)
            S_IDLE: begin
                // Refill is applied first so a same-cycle accept sees post-load counts.
                if (bus.load) begin
                    case (bus.load_coin)
                        COIN_5:  cnt5_d = sat_add(cnt5_q, bus.load_qty);
                        COIN_2:  cnt2_d = sat_add(cnt2_q, bus.load_qty);
                        COIN_1:  cnt1_d = sat_add(cnt1_q, bus.load_qty);
                        default: ;
                    endcase
                end
                if (bus.refund_valid && ready_q) begin
                    rem_d       = bus.refund_amt;
                    shortfall_d = '0;
                    state_d     = S_SELECT;
                end
            end

            S_SELECT: begin
                // Largest eligible coin first; whatever cannot be paid becomes the shortfall.
                if (rem_q >= AMT_W'(5) && cnt5_q != '0) begin
                    coin_out_d = COIN_5;
                    state_d    = S_PAY;
                end else if (rem_q >= AMT_W'(2) && cnt2_q != '0) begin
                    coin_out_d = COIN_2;
                    state_d    = S_PAY;
                end else if (rem_q >= AMT_W'(1) && cnt1_q != '0) begin
                    coin_out_d = COIN_1;
                    state_d    = S_PAY;
                end else begin
                    shortfall_d = rem_q;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
                if (state_d == S_PAY) begin
                    coin_req_d = 1'b1;
                    tmo_d      = '0;
                end
            end

            S_PAY: begin
                if (bus.coin_ack) begin
                    rem_d = rem_q - coin_value(coin_out_q);
                    case (coin_out_q)
                        COIN_5:  cnt5_d = cnt5_q - CNT_W'(1);
                        COIN_2:  cnt2_d = cnt2_q - CNT_W'(1);
                        COIN_1:  cnt1_d = cnt1_q - CNT_W'(1);
                        default: ;
                    endcase
                    coin_req_d = 1'b0;
                    coin_out_d = COIN_NONE;
                    state_d    = S_GAP;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    // The unacknowledged coin is not counted as paid.
                    coin_req_d  = 1'b0;
                    coin_out_d  = COIN_NONE;
                    fault_d     = 1'b1;
                    done_d      = 1'b1;
                    shortfall_d = rem_q;
                    state_d     = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_GAP: begin
                if (!bus.coin_ack) begin
                    state_d = S_SELECT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        empty_d = {cnt5_d == '0, cnt2_d == '0, cnt1_d == '0};
    end

    // State and output registers; reset restores the loaded inventory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            shortfall_q <= '0;
            cnt5_q      <= CNT_W'(INIT_CNT5);
            cnt2_q      <= CNT_W'(INIT_CNT2);
            cnt1_q      <= CNT_W'(INIT_CNT1);
            tmo_q       <= '0;
            coin_req_q  <= 1'b0;
            coin_out_q  <= COIN_NONE;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            empty_q     <= {INIT_CNT5 == 0, INIT_CNT2 == 0, INIT_CNT1 == 0};
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            shortfall_q <= shortfall_d;
            cnt5_q      <= cnt5_d;
            cnt2_q      <= cnt2_d;
            cnt1_q      <= cnt1_d;
            tmo_q       <= tmo_d;
            coin_req_q  <= coin_req_d;
            coin_out_q  <= coin_out_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            empty_q     <= empty_d;
        end
    end

    assign bus.refund_ready = ready_q;
    assign bus.coin_req     = coin_req_q;
    assign bus.coin_out     = coin_out_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.shortfall    = shortfall_q;
    assign bus.fault        = fault_q;
    assign bus.coin_empty   = empty_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
module tb_change_dispenser;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(7), .CNT_W(4)) bus ();

    change_dispenser dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference inventory, indexed by coin code: 0=Rs1, 1=Rs2, 2=Rs5.
    int cnt [3];
    int coin_val [3] = '{1, 2, 5};

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int empty_of(input int c [3]);
        return ((c[2] == 0) ? 4 : 0) + ((c[1] == 0) ? 2 : 0) + ((c[0] == 0) ? 1 : 0);
    endfunction

    task automatic model_load(input int coin, input int qty);
        if (coin != 3) begin
            cnt[coin] = (cnt[coin] + qty > 15) ? 15 : cnt[coin] + qty;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.coin_ack     = 1'b0;
        bus.refund_valid = 1'b0;
        bus.load         = 1'b0;
        #1;
        check("rst_coin_req", bus.coin_req, 0);
        check("rst_coin_out", bus.coin_out, 3);
        check("rst_ready", bus.refund_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_shortfall", bus.shortfall, 0);
        check("rst_empty", bus.coin_empty, 0);
        cnt = '{10, 10, 10};
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_load(input int coin, input int qty);
        bus.load      = 1'b1;
        bus.load_coin = 2'(coin);
        bus.load_qty  = 4'(qty);
        model_load(coin, qty);
        @(negedge clk);
        bus.load = 1'b0;
        check("load_empty", bus.coin_empty, empty_of(cnt));
    endtask

    // Issue one refund and play the hopper; optionally load in the accept cycle.
    task automatic do_refund(input int amt, input bit with_load, input int lcoin, input int lqty);
        int exp_q [$];
        int c [3];
        int rem;
        int cyc;
        int idx;
        int w;
        bit first;
        bit got_done;
        bit picked;

        check("ready_idle", bus.refund_ready, 1);
        bus.refund_valid = 1'b1;
        bus.refund_amt   = 7'(amt);
        if (with_load) begin
            bus.load      = 1'b1;
            bus.load_coin = 2'(lcoin);
            bus.load_qty  = 4'(lqty);
            model_load(lcoin, lqty);
        end

        // Greedy payout plan from the post-load inventory.
        c   = cnt;
        rem = amt;
        picked = 1'b1;
        while (picked) begin
            picked = 1'b0;
            for (int k = 2; k >= 0; k--) begin
                if (!picked && rem >= coin_val[k] && c[k] > 0) begin
                    exp_q.push_back(k);
                    rem -= coin_val[k];
                    c[k]--;
                    picked = 1'b1;
                end
            end
        end

        @(negedge clk);
        bus.refund_valid = 1'b0;
        bus.load         = 1'b0;
        cyc = 1;
        check("busy_after_accept", bus.busy, 1);
        check("ready_after_accept", bus.refund_ready, 0);

        idx = 0;
        first = 1'b1;
        got_done = 1'b0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (first && (bus.done || bus.coin_req)) begin
                check("first_event_latency", cyc, 2);
                first = 1'b0;
            end
            if (bus.done) begin
                bus.refund_valid = 1'b0;
                bus.load         = 1'b0;
                got_done = 1'b1;
                break;
            end
            if (bus.coin_req) begin
                bus.refund_valid = 1'b0;
                bus.load         = 1'b0;
                check("coin", bus.coin_out, (idx < exp_q.size()) ? exp_q[idx] : 3);
                idx++;
                w = $urandom_range(0, 3);
                for (int d = 0; d < w; d++) begin
                    bus.load      = 1'($urandom_range(0, 1));
                    bus.load_coin = 2'($urandom_range(0, 3));
                    bus.load_qty  = 4'($urandom_range(0, 15));
                    @(negedge clk);
                    cyc++;
                    check("req_hold", bus.coin_req, 1);
                end
                bus.load     = 1'b0;
                bus.coin_ack = 1'b1;
                w = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                    w++;
                end while (bus.coin_req && w < 5);
                check("req_drop", bus.coin_req, 0);
                check("coin_out_idle", bus.coin_out, 3);
                w = $urandom_range(0, 2);
                for (int d = 0; d < w; d++) begin
                    @(negedge clk);
                    cyc++;
                end
                bus.coin_ack = 1'b0;
            end else begin
                // Requests and refills while busy must be ignored.
                bus.refund_valid = 1'($urandom_range(0, 1));
                bus.refund_amt   = 7'($urandom_range(0, 127));
                bus.load         = 1'($urandom_range(0, 1));
                bus.load_coin    = 2'($urandom_range(0, 3));
                bus.load_qty     = 4'($urandom_range(0, 15));
            end
        end

        check("done_seen", got_done, 1);
        check("coins_paid", idx, exp_q.size());
        check("shortfall", bus.shortfall, rem);
        check("fault_clear", bus.fault, 0);
        cnt = c;
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("busy_idle", bus.busy, 0);
        check("ready_again", bus.refund_ready, 1);
        check("shortfall_hold", bus.shortfall, rem);
        check("coin_empty", bus.coin_empty, empty_of(cnt));
    endtask

    // Hopper never acknowledges: expect a timeout fault after 15 PAY cycles.
    task automatic fault_test(input int amt);
        int n;
        bus.refund_valid = 1'b1;
        bus.refund_amt   = 7'(amt);
        @(negedge clk);
        bus.refund_valid = 1'b0;
        @(negedge clk);
        check("flt_req_rise", bus.coin_req, 1);
        n = 0;
        while (bus.coin_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("flt_pay_cycles", n, 15);
        check("flt_fault", bus.fault, 1);
        check("flt_done", bus.done, 1);
        check("flt_shortfall", bus.shortfall, amt);
        check("flt_coin_out", bus.coin_out, 3);
        @(negedge clk);
        check("flt_done_pulse", bus.done, 0);
        check("flt_ready", bus.refund_ready, 0);
        check("flt_sticky", bus.fault, 1);
        bus.refund_valid = 1'b1;
        bus.refund_amt   = 7'd3;
        repeat (4) @(negedge clk);
        bus.refund_valid = 1'b0;
        check("flt_no_accept", bus.coin_req, 0);
        check("flt_ready_low", bus.refund_ready, 0);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.refund_valid = 1'b0;
        bus.refund_amt   = '0;
        bus.coin_ack     = 1'b0;
        bus.load         = 1'b0;
        bus.load_coin    = 2'b11;
        bus.load_qty     = '0;
        cnt = '{10, 10, 10};

        apply_reset();

        // Directed scenarios: full stock, zero refund, fives drained, 2/1 drained, saturation.
        do_refund(8, 1'b0, 3, 0);
        do_refund(0, 1'b0, 3, 0);
        do_refund(50, 1'b0, 3, 0);
        do_refund(7, 1'b0, 3, 0);
        do_refund(14, 1'b0, 3, 0);
        do_refund(9, 1'b0, 3, 0);
        do_refund(4, 1'b0, 3, 0);
        do_load(0, 15);
        do_load(0, 15);
        do_load(3, 7);
        do_refund(20, 1'b0, 3, 0);
        do_refund(6, 1'b1, 2, 2);

        // Randomized refunds and refills.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load($urandom_range(0, 3), $urandom_range(0, 15));
            end
            do_refund($urandom_range(0, 45), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 15));
        end

        apply_reset();
        fault_test(5);

        // Reset in the middle of a coin handshake.
        apply_reset();
        bus.refund_valid = 1'b1;
        bus.refund_amt   = 7'd8;
        @(negedge clk);
        bus.refund_valid = 1'b0;
        @(negedge clk);
        check("midpay_req", bus.coin_req, 1);
        apply_reset();
        do_refund(8, 1'b0, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
